add_sequencer: RTL
==================

ADD_SEQUENCER -- requirements
Module: add_sequencer

Interface
REQ-001 Parameters: none; address width fixed at 5 bits, data width fixed at 8 bits.
REQ-002 clock  input  1  single clock; all state updates on posedge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 op  input  1  0 = add (A+B), 1 = subtract (A-B); latched with start.
REQ-006 addr_a, addr_b, addr_dst  input  5 each  operand A, operand B and destination addresses; latched with start.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle completion pulse.
REQ-009 result  output  8  last computed result; held until next DONE.
REQ-010 carry  output  1  add: carry-out; subtract: borrow (A<B); held with result.
REQ-011 mem_read  output  1  read strobe to memory.
REQ-012 mem_write  output  1  write strobe to memory.
REQ-013 mem_address  output  5  memory address.
REQ-014 mem_wdata  output  8  write data to memory data_in.
REQ-015 mem_rdata  input  8  memory data_out; registered, valid the cycle after the edge that sampled mem_read=1.

Function
REQ-016 FSM states: IDLE, RD_A, WAIT_A, RD_B, WAIT_B, WRITE, DONE; all outputs decoded from registered state and registers only (no input-to-output combinational path).
REQ-017 IDLE: start=1 at an edge latches op and all three addresses, then moves to RD_A; start=0 stays in IDLE.
REQ-018 RD_A: mem_read=1, mem_address=addr_a; next state WAIT_A.
REQ-019 WAIT_A: mem_read=0; at the exiting edge op_a <= mem_rdata; next state RD_B.
REQ-020 RD_B: mem_read=1, mem_address=addr_b; next state WAIT_B.
REQ-021 WAIT_B: at the exiting edge op_b <= mem_rdata; next state WRITE.
REQ-022 WRITE: mem_write=1, mem_address=addr_dst, mem_wdata=(op_a ± op_b) mod 256; next state DONE.
REQ-023 DONE: done=1; result and carry update at the edge entering DONE; next state IDLE unconditionally.
REQ-024 Arithmetic: 9-bit internal sum; add: carry = bit 8 of A+B; subtract: result = (A-B) mod 256, carry = 1 iff A<B.
REQ-025 Latency: start sampled at edge E0 -> done high during cycle E5..E6; one operation per 7 cycles minimum.
REQ-026 mem_read and mem_write never high in the same cycle; each is high for exactly one cycle per operation.
REQ-027 Outside RD_A/RD_B/WRITE: mem_read=0, mem_write=0, mem_address=0, mem_wdata=0.
REQ-028 start while busy (including DONE) is ignored; no queuing.
REQ-029 Changes on op/address inputs after the start edge have no effect on the current operation.
REQ-030 addr_dst equal to addr_a or addr_b is legal; both reads complete before the write.
REQ-031 addr_a equal to addr_b is legal; the location is read twice.

Reset
REQ-032 reset=1 forces IDLE immediately, independent of clock.
REQ-033 Reset values: busy=0, done=0, result=8'h00, carry=0, mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, internal operand registers 0.
REQ-034 reset asserted mid-operation aborts it; no mem_write is issued for the aborted operation.

Verification
REQ-035 Bench memory: 32x8, registered read, mem[3]=8'h25, mem[7]=8'h17; start, op=0, a=3, b=7, dst=10 -> one write mem[10]=8'h3C, result=8'h3C, carry=0, done 5 cycles after start edge.
REQ-036 Overflow: mem[1]=8'hF0, mem[2]=8'h20, op=0 -> write 8'h10, carry=1.
REQ-037 Subtract: mem[4]=8'h05, mem[5]=8'h09, op=1 -> write 8'hFC, carry=1; swapped operands -> 8'h04, carry=0.
REQ-038 Reset asserted during WAIT_B -> busy=0 same cycle, no mem_write, result keeps reset value 8'h00.
REQ-039 start held high continuously, addresses changed mid-operation -> operations spaced exactly 7 cycles, each uses addresses present at its own start edge, done single-cycle each.
REQ-040 dst=a: mem[6]=8'h11, a=6, b=6, dst=6, op=0 -> mem[6]=8'h22 after write; read strobes precede the write strobe.

Source files
------------

// File: rtl/add_sequencer_if.sv
// Bundles the command/status handshake and the memory bus of the add sequencer.
// The master side issues commands and models the memory; the slave side is the
// sequencer itself.
interface add_sequencer_if;
    logic       start;
    logic       op;
    logic [4:0] addr_a;
    logic [4:0] addr_b;
    logic [4:0] addr_dst;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       carry;
    logic       mem_read;
    logic       mem_write;
    logic [4:0] mem_address;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    modport master (
        output start, op, addr_a, addr_b, addr_dst, mem_rdata,
        input  busy, done, result, carry, mem_read, mem_write, mem_address, mem_wdata
    );

    modport slave (
        input  start, op, addr_a, addr_b, addr_dst, mem_rdata,
        output busy, done, result, carry, mem_read, mem_write, mem_address, mem_wdata
    );
endinterface

// File: rtl/add_sequencer.sv
// Memory-to-memory add/subtract sequencer: reads operand A and operand B from a
// registered-read memory, writes A+B or A-B back to a destination address and
// reports the result and carry/borrow with a one-cycle done pulse.
module add_sequencer (
    input  logic          clock,
    input  logic          reset,
    add_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        WAIT_A,
        RD_B,
        WAIT_B,
        WRITE,
        DONE
    } state_t;

    state_t     state;
    state_t     state_next;

    logic       op_q;
    logic [4:0] addr_a_q;
    logic [4:0] addr_b_q;
    logic [4:0] addr_dst_q;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [7:0] result_q;
    logic       carry_q;
    logic [8:0] sum9;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a fixed walk through the read/read/write sequence once started.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.start) state_next = RD_A;
            RD_A:    state_next = WAIT_A;
            WAIT_A:  state_next = RD_B;
            RD_B:    state_next = WAIT_B;
            WAIT_B:  state_next = WRITE;
            WRITE:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Command capture: op and addresses are frozen at the start edge so later input changes are ignored.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q       <= 1'b0;
            addr_a_q   <= 5'd0;
            addr_b_q   <= 5'd0;
            addr_dst_q <= 5'd0;
        end else if (state == IDLE && bus.start) begin
            op_q       <= bus.op;
            addr_a_q   <= bus.addr_a;
            addr_b_q   <= bus.addr_b;
            addr_dst_q <= bus.addr_dst;
        end
    end

    // Operand capture: memory data is valid during the wait state following each read strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_a <= 8'h00;
            op_b <= 8'h00;
        end else begin
            if (state == WAIT_A) op_a <= bus.mem_rdata;
            if (state == WAIT_B) op_b <= bus.mem_rdata;
        end
    end

    // 9-bit arithmetic: bit 8 is the add carry, or the borrow (A<B) when subtracting.
    always_comb begin
        sum9 = 9'd0;
        if (op_q) begin
            sum9 = {1'b0, op_a} - {1'b0, op_b};
        end else begin
            sum9 = {1'b0, op_a} + {1'b0, op_b};
        end
    end

    // Result and carry are updated on the edge entering DONE and held until the next completion.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result_q <= 8'h00;
            carry_q  <= 1'b0;
        end else if (state == WRITE) begin
            result_q <= sum9[7:0];
            carry_q  <= sum9[8];
        end
    end

    // Memory bus decode from the registered state only; the bus is idle (all zero) outside strobe states.
    always_comb begin
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_address = 5'd0;
        bus.mem_wdata   = 8'h00;
        unique case (state)
            RD_A: begin
                bus.mem_read    = 1'b1;
                bus.mem_address = addr_a_q;
            end
            RD_B: begin
                bus.mem_read    = 1'b1;
                bus.mem_address = addr_b_q;
            end
            WRITE: begin
                bus.mem_write   = 1'b1;
                bus.mem_address = addr_dst_q;
                bus.mem_wdata   = sum9[7:0];
            end
            default: begin
                bus.mem_read = 1'b0;
            end
        endcase
    end

    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);
    assign bus.result = result_q;
    assign bus.carry  = carry_q;

endmodule
